// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: circular queue of fetched
// instructions carrying PC, fetch exception, branch flag and delay-slot tag.
module inst_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [FETCH_WIDTH-1:0]   in_valid_i,
  input  logic [32*FETCH_WIDTH-1:0] in_pc_i,
  input  logic [32*FETCH_WIDTH-1:0] in_inst_i,
  input  logic [FETCH_WIDTH-1:0]   in_addr_exc_i,
  output logic                     in_ready_o,
  output logic [ISSUE_WIDTH-1:0]   out_valid_o,
  output logic [32*ISSUE_WIDTH-1:0] out_pc_o,
  output logic [32*ISSUE_WIDTH-1:0] out_inst_o,
  output logic [ISSUE_WIDTH-1:0]   out_addr_exc_o,
  output logic [ISSUE_WIDTH-1:0]   out_is_in_delayslot_o,
  output logic [ISSUE_WIDTH-1:0]   out_is_branch_o,
  input  logic [1:0]               deq_num_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // MIPS branch/jump decode: J, JAL, BEQ..BGTZ, REGIMM branches, JR/JALR.
  function automatic logic is_branch_f(input logic [31:0] inst);
    logic       br;
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    op    = inst[31:26];
    rt    = inst[20:16];
    funct = inst[5:0];
    case (op)
      6'b000010, 6'b000011, 6'b000100,
      6'b000101, 6'b000110, 6'b000111: br = 1'b1;
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001, 5'b10000, 5'b10001: br = 1'b1;
          default: br = 1'b0;
        endcase
      end
      6'b000000: br = (funct == 6'b001000) || (funct == 6'b001001);
      default:   br = 1'b0;
    endcase
    return br;
  endfunction

  logic [31:0]      pc_mem_r   [DEPTH];
  logic [31:0]      inst_mem_r [DEPTH];
  logic [DEPTH-1:0] exc_mem_r;
  logic [DEPTH-1:0] br_mem_r;
  logic [DEPTH-1:0] ds_mem_r;

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          last_br_r;

  logic [FETCH_WIDTH-1:0] slot_we_s;
  logic [FETCH_WIDTH-1:0] slot_br_s;
  logic [FETCH_WIDTH-1:0] slot_ds_s;
  logic [AW-1:0]          slot_idx_s [FETCH_WIDTH];
  logic                   chain_br_s;
  logic                   last_br_next_s;
  logic [CW-1:0]          enq_n_s;

  logic [ISSUE_WIDTH-1:0] out_valid_s;
  logic [AW-1:0]          rd_idx_s [ISSUE_WIDTH];
  logic [CW-1:0]          issue_n_s;
  logic [CW-1:0]          deq_req_s;
  logic [CW-1:0]          deq_n_s;

  // Ready is derived from the registered count only, never from this cycle's dequeue.
  assign in_ready_o = ((CW'(DEPTH) - count_r) >= CW'(FETCH_WIDTH));
  assign count_o    = count_r;

  // Enqueue slot decode; delay-slot tag chains from last_br through the group.
  always_comb begin
    enq_n_s        = '0;
    chain_br_s     = last_br_r;
    last_br_next_s = last_br_r;
    slot_we_s      = '0;
    slot_br_s      = '0;
    slot_ds_s      = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_idx_s[k] = tail_r + AW'(k);
      slot_br_s[k]  = is_branch_f(in_inst_i[32*k +: 32]);
      slot_ds_s[k]  = chain_br_s;
      chain_br_s    = slot_br_s[k];
      slot_we_s[k]  = in_ready_o && in_valid_i[k] && !flush_i;
      if (slot_we_s[k]) begin
        enq_n_s        = enq_n_s + CW'(1);
        last_br_next_s = slot_br_s[k];
      end else begin
        enq_n_s        = enq_n_s;
        last_br_next_s = last_br_next_s;
      end
    end
  end

  // Head-side read, issue validity and clamped dequeue count.
  always_comb begin
    out_valid_s           = '0;
    issue_n_s             = '0;
    out_pc_o              = '0;
    out_inst_o            = '0;
    out_addr_exc_o        = '0;
    out_is_in_delayslot_o = '0;
    out_is_branch_o       = '0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      rd_idx_s[j]              = head_r + AW'(j);
      out_pc_o[32*j +: 32]     = pc_mem_r[rd_idx_s[j]];
      out_inst_o[32*j +: 32]   = inst_mem_r[rd_idx_s[j]];
      out_addr_exc_o[j]        = exc_mem_r[rd_idx_s[j]];
      out_is_in_delayslot_o[j] = ds_mem_r[rd_idx_s[j]];
      out_is_branch_o[j]       = br_mem_r[rd_idx_s[j]];
      // A branch never issues in slot 1, so it always pairs with its delay slot later.
      if (j == 0) begin
        out_valid_s[j] = (count_r > CW'(j));
      end else begin
        out_valid_s[j] = (count_r > CW'(j)) && !br_mem_r[rd_idx_s[j]] && out_valid_s[j-1];
      end
      issue_n_s = issue_n_s + CW'(out_valid_s[j]);
    end
    deq_req_s = {{(CW-2){1'b0}}, deq_num_i};
    if (deq_req_s > issue_n_s) begin
      deq_n_s = issue_n_s;
    end else begin
      deq_n_s = deq_req_s;
    end
  end

  assign out_valid_o = out_valid_s;

  // Pointer, occupancy and branch-history registers; flush outranks enqueue/dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      last_br_r <= 1'b0;
    end else if (flush_i) begin
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      last_br_r <= 1'b0;
    end else begin
      head_r    <= head_r + deq_n_s[AW-1:0];
      tail_r    <= tail_r + enq_n_s[AW-1:0];
      count_r   <= count_r + enq_n_s - deq_n_s;
      last_br_r <= last_br_next_s;
    end
  end

  // Entry storage, zeroed on reset so never-written entries read as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 32'h0;
        inst_mem_r[i] <= 32'h0;
      end
      exc_mem_r <= '0;
      br_mem_r  <= '0;
      ds_mem_r  <= '0;
    end else begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (slot_we_s[k]) begin
          pc_mem_r[slot_idx_s[k]]   <= in_pc_i[32*k +: 32];
          inst_mem_r[slot_idx_s[k]] <= in_inst_i[32*k +: 32];
          exc_mem_r[slot_idx_s[k]]  <= in_addr_exc_i[k];
          br_mem_r[slot_idx_s[k]]   <= slot_br_s[k];
          ds_mem_r[slot_idx_s[k]]   <= slot_ds_s[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomised
// stream checked against a scoreboard of queued entries.
module tb_inst_queue;

  localparam int DEPTH = 8;

  localparam logic [31:0] I_ADDU = 32'h00851021;
  localparam logic [31:0] I_ORI  = 32'h34420001;
  localparam logic [31:0] I_BEQ  = 32'h10000003;
  localparam logic [31:0] I_NOP  = 32'h00000000;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_LW   = 32'h8C820000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        ds;
    logic        br;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [1:0]  in_valid_i;
  logic [63:0] in_pc_i;
  logic [63:0] in_inst_i;
  logic [1:0]  in_addr_exc_i;
  logic        in_ready_o;
  logic [1:0]  out_valid_o;
  logic [63:0] out_pc_o;
  logic [63:0] out_inst_o;
  logic [1:0]  out_addr_exc_o;
  logic [1:0]  out_is_in_delayslot_o;
  logic [1:0]  out_is_branch_o;
  logic [1:0]  deq_num_i;
  logic [3:0]  count_o;

  entry_t      sb[$];
  logic        m_last_br;
  int          pass_cnt;
  int          check_cnt;
  logic [31:0] itab [8];
  logic [31:0] pc_next;

  inst_queue #(.DEPTH(8), .FETCH_WIDTH(2), .ISSUE_WIDTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush_i               (flush_i),
    .in_valid_i            (in_valid_i),
    .in_pc_i               (in_pc_i),
    .in_inst_i             (in_inst_i),
    .in_addr_exc_i         (in_addr_exc_i),
    .in_ready_o            (in_ready_o),
    .out_valid_o           (out_valid_o),
    .out_pc_o              (out_pc_o),
    .out_inst_o            (out_inst_o),
    .out_addr_exc_o        (out_addr_exc_o),
    .out_is_in_delayslot_o (out_is_in_delayslot_o),
    .out_is_branch_o       (out_is_branch_o),
    .deq_num_i             (deq_num_i),
    .count_o               (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic ref_br(input logic [31:0] w);
    logic [5:0] op;
    logic [4:0] rt;
    op = w[31:26];
    rt = w[20:16];
    return (op >= 6'd2 && op <= 6'd7) ||
           (op == 6'd1 && (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17)) ||
           (op == 6'd0 && (w[5:0] == 6'd8 || w[5:0] == 6'd9));
  endfunction

  function automatic logic [1:0] exp_valid();
    logic [1:0] v;
    v = 2'b00;
    if (sb.size() >= 1) v[0] = 1'b1;
    if (sb.size() >= 2) v[1] = !sb[1].br;
    return v;
  endfunction

  // Apply one cycle of stimulus at a negedge, update the model, return at the next negedge.
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] inst0,
                       input logic [31:0] pc1, input logic [31:0] inst1,
                       input logic [1:0] exc, input logic [1:0] deq, input logic fl);
    logic       rdy;
    logic       prev;
    logic [1:0] ev;
    int         nv;
    int         de;
    entry_t     e;
    in_valid_i    = v;
    in_pc_i       = {pc1, pc0};
    in_inst_i     = {inst1, inst0};
    in_addr_exc_i = exc;
    deq_num_i     = deq;
    flush_i       = fl;
    rdy = ((DEPTH - sb.size()) >= 2);
    if (fl) begin
      sb.delete();
      m_last_br = 1'b0;
    end else begin
      ev = exp_valid();
      nv = int'(ev[0]) + int'(ev[1]);
      de = (int'(deq) > nv) ? nv : int'(deq);
      for (int i = 0; i < de; i++) void'(sb.pop_front());
      if (rdy) begin
        prev = m_last_br;
        for (int k = 0; k < 2; k++) begin
          if (v[k]) begin
            e.pc   = (k == 0) ? pc0 : pc1;
            e.inst = (k == 0) ? inst0 : inst1;
            e.exc  = exc[k];
            e.br   = ref_br(e.inst);
            e.ds   = prev;
            prev   = e.br;
            sb.push_back(e);
          end
        end
        m_last_br = prev;
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_i    = 2'b00;
    in_addr_exc_i = 2'b00;
    deq_num_i     = 2'b00;
    flush_i       = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) begin
      drive(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 2'b00, 2'd2, 1'b0);
    end
  endtask

  task automatic test_reset();
    check_cnt++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready_o); else pass_cnt++;
    check_cnt++;
    if (out_valid_o !== 2'b00) $display("FAIL reset_out_valid got %b want 00", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (count_o !== 4'd0) $display("FAIL reset_count got %0d want 0", count_o); else pass_cnt++;
    check_cnt++;
    if ({out_pc_o, out_inst_o} !== 128'h0) $display("FAIL reset_data got %h want 0", {out_pc_o, out_inst_o}); else pass_cnt++;
    check_cnt++;
    if ({out_addr_exc_o, out_is_in_delayslot_o, out_is_branch_o} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {out_addr_exc_o, out_is_in_delayslot_o, out_is_branch_o});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    drive(2'b11, 32'h1000, I_ADDU, 32'h1004, I_ORI, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b11) $display("FAIL basic_valid got %b want 11", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (out_pc_o !== {32'h1004, 32'h1000}) $display("FAIL basic_pcs got %h want 0000100400001000", out_pc_o); else pass_cnt++;
    check_cnt++;
    if (out_is_in_delayslot_o !== 2'b00) $display("FAIL basic_ds got %b want 00", out_is_in_delayslot_o); else pass_cnt++;
    check_cnt++;
    if (count_o !== 4'd2) $display("FAIL basic_count got %0d want 2", count_o); else pass_cnt++;
    drive(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 2'b00, 2'd2, 1'b0);
    check_cnt++;
    if (count_o !== 4'd0) $display("FAIL basic_drain_count got %0d want 0", count_o); else pass_cnt++;
    check_cnt++;
    if (out_valid_o !== 2'b00) $display("FAIL basic_drain_valid got %b want 00", out_valid_o); else pass_cnt++;
  endtask

  task automatic test_branch_pair();
    drive(2'b11, 32'h2000, I_BEQ, 32'h2004, I_NOP, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b11) $display("FAIL brpair_valid got %b want 11", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (out_is_in_delayslot_o !== 2'b10) $display("FAIL brpair_ds got %b want 10", out_is_in_delayslot_o); else pass_cnt++;
    check_cnt++;
    if (out_is_branch_o !== 2'b01) $display("FAIL brpair_branch got %b want 01", out_is_branch_o); else pass_cnt++;
    drain();
  endtask

  task automatic test_cross_group();
    drive(2'b11, 32'h3000, I_ADDU, 32'h3004, I_JR, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b01) $display("FAIL xgrp_valid1 got %b want 01", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (out_pc_o[31:0] !== 32'h3000) $display("FAIL xgrp_pc0 got %h want 00003000", out_pc_o[31:0]); else pass_cnt++;
    drive(2'b11, 32'h3008, I_NOP, 32'h300C, I_LW, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (count_o !== 4'd4) $display("FAIL xgrp_count got %0d want 4", count_o); else pass_cnt++;
    drive(2'b00, 32'h0, I_NOP, 32'h0, I_NOP, 2'b00, 2'd1, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b11) $display("FAIL xgrp_valid2 got %b want 11", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (out_pc_o !== {32'h3008, 32'h3004}) $display("FAIL xgrp_pcs got %h want 0000300800003004", out_pc_o); else pass_cnt++;
    check_cnt++;
    if (out_is_in_delayslot_o !== 2'b10) $display("FAIL xgrp_ds got %b want 10", out_is_in_delayslot_o); else pass_cnt++;
    check_cnt++;
    if (out_is_branch_o !== 2'b01) $display("FAIL xgrp_branch got %b want 01", out_is_branch_o); else pass_cnt++;
    drain();
    check_cnt++;
    if (count_o !== 4'd0) $display("FAIL xgrp_drained got %0d want 0", count_o); else pass_cnt++;
  endtask

  task automatic test_fill_wrap();
    logic [1:0]  ev;
    logic [1:0]  v;
    logic [31:0] ia;
    logic [31:0] ib;
    entry_t      got;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, pc_next, I_ADDU, pc_next + 32'd4, I_ORI, 2'b00, 2'd0, 1'b0);
      pc_next = pc_next + 32'd8;
      check_cnt++;
      if (count_o !== 4'(sb.size()) || count_o > 4'd8)
        $display("FAIL fill_count got %0d want %0d", count_o, sb.size());
      else pass_cnt++;
    end
    check_cnt++;
    if (in_ready_o !== 1'b0 || count_o !== 4'd8) $display("FAIL full_state got rdy=%b cnt=%0d want rdy=0 cnt=8", in_ready_o, count_o); else pass_cnt++;
    drive(2'b11, 32'hDEAD0000, I_ADDU, 32'hDEAD0004, I_ADDU, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (count_o !== 4'd8) $display("FAIL full_ignore got %0d want 8", count_o); else pass_cnt++;
    for (int it = 0; it < 48; it++) begin
      ev = exp_valid();
      check_cnt++;
      if (out_valid_o !== ev) $display("FAIL stream_valid got %b want %b", out_valid_o, ev); else pass_cnt++;
      check_cnt++;
      if (count_o !== 4'(sb.size()) || count_o > 4'd8) $display("FAIL stream_count got %0d want %0d", count_o, sb.size()); else pass_cnt++;
      check_cnt++;
      if (in_ready_o !== ((DEPTH - sb.size()) >= 2)) $display("FAIL stream_ready got %b want %b", in_ready_o, ((DEPTH - sb.size()) >= 2)); else pass_cnt++;
      for (int s = 0; s < 2; s++) begin
        if (ev[s]) begin
          got = {out_pc_o[32*s +: 32], out_inst_o[32*s +: 32], out_addr_exc_o[s], out_is_in_delayslot_o[s], out_is_branch_o[s]};
          check_cnt++;
          if (got !== sb[s]) $display("FAIL stream_entry%0d got %h want %h", s, got, sb[s]); else pass_cnt++;
        end
      end
      case ($urandom_range(0, 3))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      ia = itab[$urandom_range(0, 7)];
      ib = itab[$urandom_range(0, 7)];
      drive(v, pc_next, ia, pc_next + 32'd4, ib, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1'b0);
      pc_next = pc_next + 32'd8;
    end
    drain();
    check_cnt++;
    if (count_o !== 4'(sb.size())) $display("FAIL stream_drain got %0d want %0d", count_o, sb.size()); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h6000, I_ADDU, 32'h6004, I_ORI, 2'b00, 2'd0, 1'b0);
    drive(2'b11, 32'h6008, I_ADDU, 32'h600C, I_ORI, 2'b00, 2'd0, 1'b0);
    drive(2'b01, 32'h6010, I_BEQ, 32'h0, I_NOP, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (count_o !== 4'd5) $display("FAIL flush_pre_count got %0d want 5", count_o); else pass_cnt++;
    drive(2'b11, 32'h6014, I_NOP, 32'h6018, I_BEQ, 2'b00, 2'd2, 1'b1);
    check_cnt++;
    if (count_o !== 4'd0) $display("FAIL flush_count got %0d want 0", count_o); else pass_cnt++;
    check_cnt++;
    if (out_valid_o !== 2'b00) $display("FAIL flush_valid got %b want 00", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (in_ready_o !== 1'b1) $display("FAIL flush_ready got %b want 1", in_ready_o); else pass_cnt++;
    drive(2'b01, 32'h4000, I_ADDU, 32'h0, I_NOP, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b01 || out_pc_o[31:0] !== 32'h4000)
      $display("FAIL flush_next got v=%b pc=%h want v=01 pc=00004000", out_valid_o, out_pc_o[31:0]);
    else pass_cnt++;
    check_cnt++;
    if (out_is_in_delayslot_o[0] !== 1'b0) $display("FAIL flush_ds got %b want 0", out_is_in_delayslot_o[0]); else pass_cnt++;
    drain();
  endtask

  task automatic test_async_reset();
    drive(2'b11, 32'h7000, I_ADDU, 32'h7004, I_BEQ, 2'b00, 2'd0, 1'b0);
    drive(2'b01, 32'h7008, I_NOP, 32'h0, I_NOP, 2'b00, 2'd0, 1'b0);
    check_cnt++;
    if (count_o !== 4'd3) $display("FAIL arst_pre_count got %0d want 3", count_o); else pass_cnt++;
    #2;
    rst = 1'b0;
    sb.delete();
    m_last_br = 1'b0;
    #1;
    check_cnt++;
    if (out_valid_o !== 2'b00) $display("FAIL arst_valid got %b want 00", out_valid_o); else pass_cnt++;
    check_cnt++;
    if (count_o !== 4'd0) $display("FAIL arst_count got %0d want 0", count_o); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    drive(2'b01, 32'h5000, I_ADDU, 32'h0, I_NOP, 2'b01, 2'd0, 1'b0);
    check_cnt++;
    if (out_valid_o !== 2'b01 || out_pc_o[31:0] !== 32'h5000)
      $display("FAIL arst_first got v=%b pc=%h want v=01 pc=00005000", out_valid_o, out_pc_o[31:0]);
    else pass_cnt++;
    check_cnt++;
    if (out_addr_exc_o[0] !== 1'b1) $display("FAIL arst_exc got %b want 1", out_addr_exc_o[0]); else pass_cnt++;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk           = 1'b0;
    rst           = 1'b0;
    flush_i       = 1'b0;
    in_valid_i    = 2'b00;
    in_pc_i       = 64'h0;
    in_inst_i     = 64'h0;
    in_addr_exc_i = 2'b00;
    deq_num_i     = 2'b00;
    m_last_br     = 1'b0;
    pass_cnt      = 0;
    check_cnt     = 0;
    pc_next       = 32'h8000;
    itab[0] = I_ADDU;
    itab[1] = I_ORI;
    itab[2] = I_LW;
    itab[3] = I_BEQ;
    itab[4] = I_JR;
    itab[5] = 32'h08000010;
    itab[6] = 32'h04010002;
    itab[7] = 32'h04020002;
    #12;
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_basic();
    test_branch_pair();
    test_cross_group();
    test_fill_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
